u_hazard_ctl: RTL

U_HAZARD_CTL -- requirements
Module: u_hazard_ctl

---
 rtl/u_hazard_ctl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/u_hazard_ctl.sv
// u_hazard_ctl -- register scoreboard and issue interlock for an in-order pipe.
//
// Each architectural register x1..x31 has a pending-write entry: a busy bit,
// a load flag and a writeback countdown. The issue gate stalls decode on RAW,
// WAW or too many outstanding loads.
//
// Ports
//   clk, rstn              clock, async active-low reset
//   issue_vld / issue_rdy  decode handshake (issue_rdy is combinational)
//   rs1_a/rs2_a, *_used    source operands and whether they are read
//   rd_a, rd_we, is_ld     destination, write enable, load marker
//   ld_wb_vld, ld_wb_a     LSU regfile write
//   busy_vec               registered per-register pending-write flags (bit0=0)
//   ld_cnt                 outstanding loads
//   stall_cnt              saturating count of stalled cycles
//   ld_err                 sticky: load writeback hit a non-load-pending reg

// One scoreboard entry. A non-load allocation stores WB_LAT-1 because the
// allocating edge itself counts as the first countdown step; busy then drops
// on the edge where the counter goes 1->0, so a dependent may fire exactly
// WB_LAT cycles after its producer.
module u_hazard_reg #(
  parameter int WB_LAT = 4,
  parameter int CW     = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic alloc,
  input  logic alloc_ld,
  input  logic wb_hit,
  output logic busy,
  output logic ld_pend
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy    <= 1'b0;
      ld_pend <= 1'b0;
      cnt     <= '0;
    end else if (alloc) begin
      // With WB_LAT==1 the result is already written by the next cycle.
      busy    <= alloc_ld || (WB_LAT > 1);
      ld_pend <= alloc_ld;
      cnt     <= alloc_ld ? '0 : CW'(WB_LAT - 1);
    end else if (wb_hit && ld_pend) begin
      busy    <= 1'b0;
      ld_pend <= 1'b0;
    end else if (busy && !ld_pend) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end
endmodule

module u_hazard_ctl #(
  parameter int WB_LAT = 4,
  parameter int MAX_LD = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue_vld,
  output logic        issue_rdy,
  input  logic [4:0]  rs1_a,
  input  logic [4:0]  rs2_a,
  input  logic        rs1_used,
  input  logic        rs2_used,
  input  logic [4:0]  rd_a,
  input  logic        rd_we,
  input  logic        is_ld,
  input  logic        ld_wb_vld,
  input  logic [4:0]  ld_wb_a,
  output logic [31:0] busy_vec,
  output logic [2:0]  ld_cnt,
  output logic [15:0] stall_cnt,
  output logic        ld_err
);
  localparam int CW = (WB_LAT < 1) ? 1 : $clog2(WB_LAT + 1);

  logic [31:0] busy_r;
  logic [31:0] ld_pend_vec;
  logic        raw, waw, ld_lim, fire;
  logic        ld_inc, ld_dec, wb_bad;

  assign raw    = issue_vld &
                  ((rs1_used & (rs1_a != 5'd0) & busy_r[rs1_a]) |
                   (rs2_used & (rs2_a != 5'd0) & busy_r[rs2_a]));
  assign waw    = issue_vld & rd_we & (rd_a != 5'd0) & busy_r[rd_a];
  assign ld_lim = issue_vld & is_ld & (ld_cnt == 3'(MAX_LD));

  assign issue_rdy = ~(raw | waw | ld_lim);
  assign fire      = issue_vld & issue_rdy;

  assign busy_r[0]      = 1'b0;
  assign ld_pend_vec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      u_hazard_reg #(.WB_LAT(WB_LAT), .CW(CW)) u_reg (
        .clk     (clk),
        .rstn    (rstn),
        .alloc   (fire & rd_we & (rd_a == 5'(gi))),
        .alloc_ld(is_ld),
        .wb_hit  (ld_wb_vld & (ld_wb_a == 5'(gi))),
        .busy    (busy_r[gi]),
        .ld_pend (ld_pend_vec[gi])
      );
    end
  endgenerate

  assign busy_vec = busy_r;

  // Address 0 never has a pending load, so it always reads as a bad writeback.
  assign ld_inc = fire & rd_we & (rd_a != 5'd0) & is_ld;
  assign ld_dec = ld_wb_vld & ld_pend_vec[ld_wb_a];
  assign wb_bad = ld_wb_vld & ~ld_pend_vec[ld_wb_a];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_cnt    <= '0;
      stall_cnt <= '0;
      ld_err    <= 1'b0;
    end else begin
      case ({ld_inc, ld_dec})
        2'b10:   ld_cnt <= ld_cnt + 3'd1;
        2'b01:   ld_cnt <= ld_cnt - 3'd1;
        default: ld_cnt <= ld_cnt;
      endcase
      if (issue_vld && !issue_rdy && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (wb_bad) ld_err <= 1'b1;
    end
  end
endmodule
